// File: rtl/dandy_pkg.sv
// Shared types and constants for the X/Y frame sequencer.
package dandy_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam logic [7:0] DAC_MID  = 8'h80;

   typedef enum logic [1:0] {L_IDLE, L_CNT, L_X, L_Y} ld_state_e;
   typedef enum logic       {P_IDLE, P_RUN}           pl_state_e;

   // x lands in [15:8], y in [7:0]
   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
   } point_t;

endpackage

// File: rtl/xy_point_bank.sv
// Dual-bank point store: one write port, one registered read port.
// A read of the location being written in the same cycle returns the new data.
module xy_point_bank
   import dandy_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic          wbank_i,
   input  logic [AW-1:0] waddr_i,
   input  point_t        wdata_i,
   input  logic          re_i,
   input  logic          rbank_i,
   input  logic [AW-1:0] raddr_i,
   output point_t        rdata_o
);

   point_t      mem_q [2*DEPTH];
   point_t      rdata_q;
   logic [AW:0] wa, ra;

   assign wa      = {wbank_i, waddr_i};
   assign ra      = {rbank_i, raddr_i};
   assign rdata_o = rdata_q;

   // point storage; contents survive reset
   always_ff @(posedge clk)
      if (we_i) mem_q[wa] <= wdata_i;

   // registered read with write-through bypass; resets to midscale
   always_ff @(posedge clk)
      if (reset)     rdata_q <= '{x: DAC_MID, y: DAC_MID};
      else if (re_i) rdata_q <= (we_i && (wa == ra)) ? wdata_i : mem_q[ra];

endmodule

// File: rtl/xy_frame_sequencer.sv
// Double-buffered X/Y point-list player fed by a UART byte stream.
// Packet: A5, N, then N pairs (x, y). Banks swap only at a frame wrap.
// Optional: define LOAD_TIMEOUT_EN to abort a stalled load after TIMEOUT clks.
module xy_frame_sequencer
   import dandy_pkg::*;
#(
   parameter int          DEPTH   = 64,
   parameter int          DWELL   = 2,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       step,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [7:0] xdac,
   output logic [7:0] ydac,
   output logic       frame_start,
   output logic       loading,
   output logic       load_err
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [8:0]  DEPTH_W = 9'(DEPTH);
   localparam logic [15:0] DW_LAST = 16'(DWELL - 1);

   // loader
   ld_state_e   ld_q, ld_d;
   logic [8:0]  n_q, n_d, widx_q, widx_d;
   logic [7:0]  x_q, x_d;
   logic        err_q, err_d;
   logic        wr_en, ld_done, tmo_hit;
   point_t      wdata;

   // player
   pl_state_e   pl_q, pl_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [15:0] dwell_q, dwell_d;
   logic        act_q, act_d, swp_q, swp_d, fs_q, fs_d;
   logic        rd_en, swap_ok, last_pt;
   logic [8:0]  cnt_q [2];
   logic [8:0]  cnt_act;
   point_t      rdata;

   assign wdata   = '{x: x_q, y: rx_data};
   assign cnt_act = cnt_q[act_q];
   assign last_pt = (9'(idx_q) == cnt_act - 9'd1);
   // never swap onto a bank that a packet is half-way through rewriting
   assign swap_ok = ((ld_q != L_X) && (ld_q != L_Y)) || ld_done;

`ifdef LOAD_TIMEOUT_EN
   logic [15:0] tmo_q;

   // idle-byte counter, restarted by every byte and whenever not loading
   always_ff @(posedge clk)
      if (reset || ld_q == L_IDLE || rx_valid) tmo_q <= '0;
      else if (tmo_q != TIMEOUT)               tmo_q <= tmo_q + 16'd1;

   assign tmo_hit = (ld_q != L_IDLE) && !rx_valid && (tmo_q == TIMEOUT);
`else
   assign tmo_hit = 1'b0;
`endif

   // loader next-state: parse header, count and point pairs
   always_comb begin
      ld_d    = ld_q;
      n_d     = n_q;
      widx_d  = widx_q;
      x_d     = x_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      ld_done = 1'b0;
      if (rx_valid) begin
         unique case (ld_q)
            L_IDLE: if (rx_data == HDR_BYTE) ld_d = L_CNT;
            L_CNT: begin
               if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_W) begin
                  err_d = 1'b1;
                  ld_d  = L_IDLE;
               end else begin
                  n_d    = {1'b0, rx_data};
                  widx_d = '0;
                  err_d  = 1'b0;
                  ld_d   = L_X;
               end
            end
            L_X: begin
               x_d  = rx_data;
               ld_d = L_Y;
            end
            L_Y: begin
               wr_en  = 1'b1;
               widx_d = widx_q + 9'd1;
               if (widx_q + 9'd1 == n_q) begin
                  ld_done = 1'b1;
                  ld_d    = L_IDLE;
               end else begin
                  ld_d = L_X;
               end
            end
            default: ld_d = L_IDLE;
         endcase
      end else if (tmo_hit) begin
         ld_d  = L_IDLE;
         err_d = 1'b1;
      end
   end

   // loader state register
   always_ff @(posedge clk)
      if (reset) begin
         ld_q   <= L_IDLE;
         n_q    <= '0;
         widx_q <= '0;
         x_q    <= '0;
         err_q  <= 1'b0;
      end else begin
         ld_q   <= ld_d;
         n_q    <= n_d;
         widx_q <= widx_d;
         x_q    <= x_d;
         err_q  <= err_d;
      end

   // player next-state: dwell/index advance, frame wrap and bank swap
   always_comb begin
      pl_d    = pl_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      act_d   = act_q;
      swp_d   = swp_q;
      fs_d    = 1'b0;
      rd_en   = 1'b0;
      if (ld_done) begin
         // nothing playing yet: show the first frame straight away
         if (pl_q == P_IDLE && cnt_act == 9'd0) act_d = ~act_q;
         else                                   swp_d = 1'b1;
      end
      unique case (pl_q)
         P_IDLE: begin
            if (enable && cnt_act != 9'd0) begin
               pl_d    = P_RUN;
               idx_d   = '0;
               dwell_d = '0;
               rd_en   = 1'b1;
               fs_d    = 1'b1;
            end
         end
         P_RUN: begin
            if (enable && step) begin
               if (dwell_q == DW_LAST) begin
                  dwell_d = '0;
                  rd_en   = 1'b1;
                  if (last_pt) begin
                     idx_d = '0;
                     fs_d  = 1'b1;
                     if ((swp_q || ld_done) && swap_ok) begin
                        act_d = ~act_q;
                        swp_d = 1'b0;
                     end
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  dwell_d = dwell_q + 16'd1;
               end
            end
         end
         default: pl_d = P_IDLE;
      endcase
   end

   // player state register and per-bank point counts
   always_ff @(posedge clk)
      if (reset) begin
         pl_q     <= P_IDLE;
         idx_q    <= '0;
         dwell_q  <= '0;
         act_q    <= 1'b0;
         swp_q    <= 1'b0;
         fs_q     <= 1'b0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         pl_q    <= pl_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         act_q   <= act_d;
         swp_q   <= swp_d;
         fs_q    <= fs_d;
         if (ld_done) cnt_q[~act_q] <= n_q;
      end

   xy_point_bank #(.DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_en),
      .wbank_i (~act_q),
      .waddr_i (widx_q[AW-1:0]),
      .wdata_i (wdata),
      .re_i    (rd_en),
      .rbank_i (act_d),
      .raddr_i (idx_d),
      .rdata_o (rdata)
   );

   assign xdac        = rdata.x;
   assign ydac        = rdata.y;
   assign frame_start = fs_q;
   assign loading     = (ld_q != L_IDLE);
   assign load_err    = err_q;

endmodule

// File: tb/tb_xy_frame_sequencer.sv
// Directed bench for xy_frame_sequencer (DEPTH=64, DWELL=2).
module tb_xy_frame_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1, enable = 1'b0, step = 1'b0, rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] xdac, ydac;
   logic       frame_start, loading, load_err;

   int n_chk = 0;
   int n_err = 0;

   xy_frame_sequencer #(.DEPTH(64), .DWELL(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .step        (step),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .xdac        (xdac),
      .ydac        (ydac),
      .frame_start (frame_start),
      .loading     (loading),
      .load_err    (load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [7:0] x;
      logic [7:0] y;
      logic       fs;
   } vec_t;

   vec_t tbl [24];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      tick();
   endtask

   task automatic step_chk(input string nm, input logic [7:0] x, input logic [7:0] y,
                           input logic fs);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk({nm, " xy"}, {xdac, ydac}, {x, y});
      chk({nm, " fs"}, 16'(frame_start), 16'(fs));
      tick();
   endtask

   task automatic apply_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         enable = tbl[i].en;
         step_chk($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].fs);
      end
   endtask

   initial begin
      // idle steps, no frame loaded
      for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 8'h80, 8'h80, 1'b0};
      // frame A playback, DWELL=2
      tbl[4]  = '{1'b1, 8'h10, 8'h20, 1'b0};
      tbl[5]  = '{1'b1, 8'h30, 8'h40, 1'b0};
      tbl[6]  = '{1'b1, 8'h30, 8'h40, 1'b0};
      tbl[7]  = '{1'b1, 8'h50, 8'h60, 1'b0};
      tbl[8]  = '{1'b1, 8'h50, 8'h60, 1'b0};
      tbl[9]  = '{1'b1, 8'h10, 8'h20, 1'b1};
      tbl[10] = '{1'b1, 8'h10, 8'h20, 0};
      tbl[11] = '{1'b1, 8'h30, 8'h40, 1'b0};
      // enable low: frozen
      for (int i = 12; i < 22; i++) tbl[i] = '{1'b0, 8'h30, 8'h40, 1'b0};
      // resume at the same point and dwell
      tbl[22] = '{1'b1, 8'h30, 8'h40, 1'b0};
      tbl[23] = '{1'b1, 8'h50, 8'h60, 1'b0};

      // reset
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst xy", {xdac, ydac}, 16'h8080);
      chk("rst fs", 16'(frame_start), 16'h0);
      chk("rst loading", 16'(loading), 16'h0);
      chk("rst load_err", 16'(load_err), 16'h0);

      apply_range(0, 3);

      // frame A: first load swaps in immediately, point 0 comes up with frame_start
      send_byte(8'hA5);
      chk("hdr loading", 16'(loading), 16'h1);
      send_byte(8'h03);
      send_byte(8'h10); send_byte(8'h20);
      send_byte(8'h30); send_byte(8'h40);
      send_byte(8'h50); send_byte(8'h60);
      chk("A start xy", {xdac, ydac}, 16'h1020);
      chk("A start fs", 16'(frame_start), 16'h1);
      chk("A loading", 16'(loading), 16'h0);

      apply_range(4, 23);

      // frame B loaded mid-frame: A finishes, B shows at the wrap
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00);
      chk("B pending xy", {xdac, ydac}, 16'h5060);
      chk("B loading", 16'(loading), 16'h0);
      step_chk("B s1", 8'h50, 8'h60, 1'b0);
      step_chk("B wrap", 8'hFF, 8'h00, 1'b1);
      step_chk("B s3", 8'hFF, 8'h00, 1'b0);
      step_chk("B s4", 8'hFF, 8'h00, 1'b1);

      // zero count is rejected
      send_byte(8'hA5); send_byte(8'h00);
      chk("N0 err", 16'(load_err), 16'h1);
      chk("N0 loading", 16'(loading), 16'h0);

      // two loads before the wrap: the later one wins; valid packet clears error
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
      chk("C err clr", 16'(load_err), 16'h0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h33); send_byte(8'h44);
      step_chk("D s1", 8'hFF, 8'h00, 1'b0);
      step_chk("D wrap", 8'h33, 8'h44, 1'b1);

      // load completes in the same cycle as the wrap: swap happens there
      step_chk("E s1", 8'h33, 8'h44, 1'b0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55);
      rx_valid = 1'b1;
      rx_data  = 8'h66;
      step     = 1'b1;
      tick();
      rx_valid = 1'b0;
      step     = 1'b0;
      chk("E same-cycle xy", {xdac, ydac}, 16'h5566);
      chk("E same-cycle fs", 16'(frame_start), 16'h1);
      tick();

      // count one past DEPTH is rejected, playback untouched
      send_byte(8'hA5); send_byte(8'h41);
      chk("N65 err", 16'(load_err), 16'h1);
      step_chk("N65 s1", 8'h55, 8'h66, 1'b0);
      step_chk("N65 s2", 8'h55, 8'h66, 1'b1);

      // count equal to DEPTH is accepted
      send_byte(8'hA5); send_byte(8'h40);
      chk("N64 err", 16'(load_err), 16'h0);
      chk("N64 loading", 16'(loading), 16'h1);
      for (int i = 0; i < 64; i++) begin
         send_byte(8'(i));
         send_byte(8'hFF - 8'(i));
      end
      chk("N64 done", 16'(loading), 16'h0);
      step_chk("N64 s1", 8'h55, 8'h66, 1'b0);
      step_chk("N64 wrap", 8'h00, 8'hFF, 1'b1);
      step_chk("N64 s3", 8'h00, 8'hFF, 1'b0);
      step_chk("N64 s4", 8'h01, 8'hFE, 1'b0);

      // reset mid-load clears everything; counts go to zero
      send_byte(8'hA5); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h0A);
      chk("mid loading", 16'(loading), 16'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("rst2 xy", {xdac, ydac}, 16'h8080);
      chk("rst2 loading", 16'(loading), 16'h0);
      chk("rst2 err", 16'(load_err), 16'h0);
      chk("rst2 fs", 16'(frame_start), 16'h0);
      step_chk("rst2 s1", 8'h80, 8'h80, 1'b0);
      step_chk("rst2 s2", 8'h80, 8'h80, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
